// File: rtl/sm3_pkg.sv
// Shared SM3 constants and the bank-state encoding used by the block packer.
package sm3_pkg;

    localparam int SM3_BLK_W = 512;
    localparam int SM3_WD_W  = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Beats needed to fill one 512-bit block at a given beat width.
    function automatic int blk_beats(input int dw);
        return SM3_BLK_W / dw;
    endfunction

endpackage

// File: rtl/sm3_blk_bank.sv
// One ping-pong bank: 512-bit block storage, fill count, state and message flags.
module sm3_blk_bank
    import sm3_pkg::*;
#(
    parameter  int INPT_DW   = 32,
    localparam int BLK_BEATS = blk_beats(INPT_DW),
    localparam int CNT_W     = $clog2(BLK_BEATS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 beat_i,
    input  logic [INPT_DW-1:0]   beat_d_i,
    input  logic                 fst_i,
    input  logic                 cmp_i,
    input  logic                 lst_i,
    input  logic                 rel_i,
    output logic [1:0]           state_o,
    output logic [CNT_W-1:0]     cnt_o,
    output logic [SM3_BLK_W-1:0] data_o,
    output logic                 fst_o,
    output logic                 lst_o
);

    bank_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fst_q, fst_d;
    logic             lst_q, lst_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fst_d   = fst_q;
        lst_d   = lst_q;
        if (rel_i) begin
            state_d = BANK_EMPTY;
            cnt_d   = '0;
            fst_d   = 1'b0;
            lst_d   = 1'b0;
        end
        if (beat_i) begin
            if (state_q == BANK_EMPTY) begin
                fst_d = fst_i;
            end
            state_d = BANK_FILLING;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cmp_i) begin
                state_d = BANK_FULL;
                cnt_d   = '0;
                lst_d   = lst_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BANK_EMPTY;
            cnt_q   <= '0;
            fst_q   <= 1'b0;
            lst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fst_q   <= fst_d;
            lst_q   <= lst_d;
        end
    end

    // Words are cleared on release so a block closed early carries zeros in its tail.
    for (genvar gi = 0; gi < BLK_BEATS; gi++) begin : g_word
        logic [INPT_DW-1:0] word_q;

        always_ff @(posedge clk) begin
            if (rst || rel_i) begin
                word_q <= '0;
            end else if (beat_i && (cnt_q == CNT_W'(gi))) begin
                word_q <= beat_d_i;
            end
        end

        assign data_o[SM3_BLK_W-1-gi*INPT_DW -: INPT_DW] = word_q;
    end

    assign state_o = state_q;
    assign cnt_o   = cnt_q;
    assign fst_o   = fst_q;
    assign lst_o   = lst_q;

endmodule

// File: rtl/sm3_blk_pack.sv
// Packs padded SM3 beats into 512-bit blocks through two ping-pong banks.
// Optional protocol checking and the err_o port are enabled by SM3_PACK_ERR_CHK_EN.
module sm3_blk_pack
    import sm3_pkg::*;
#(
    parameter int INPT_DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INPT_DW-1:0]   pad_otpt_d_i,
    input  logic                 pad_otpt_vld_i,
    input  logic                 pad_otpt_lst_i,
    output logic                 pad_otpt_ena_o,
    output logic [SM3_BLK_W-1:0] blk_o,
    output logic                 blk_vld_o,
    output logic                 blk_fst_o,
    output logic                 blk_lst_o,
    input  logic                 blk_rdy_i
`ifdef SM3_PACK_ERR_CHK_EN
    ,output logic                err_o
`endif
);

    localparam int BLK_BEATS = blk_beats(INPT_DW);
    localparam int CNT_W     = $clog2(BLK_BEATS);

    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 fst_pend_q, fst_pend_d;

    logic [1:0]           bank_st   [2];
    logic [CNT_W-1:0]     bank_cnt  [2];
    logic [SM3_BLK_W-1:0] bank_dat  [2];
    logic                 bank_fst  [2];
    logic                 bank_lst  [2];
    logic                 bank_beat [2];
    logic                 bank_rel  [2];

    logic wr_full, wr_empty, beat_ok, last_slot, cmp, rel;

    always_comb begin
        wr_full   = (bank_st[wr_ptr_q] == BANK_FULL);
        wr_empty  = (bank_st[wr_ptr_q] == BANK_EMPTY);
        beat_ok   = pad_otpt_vld_i && !wr_full;
        last_slot = (bank_cnt[wr_ptr_q] == CNT_W'(BLK_BEATS-1));
`ifdef SM3_PACK_ERR_CHK_EN
        cmp       = beat_ok && (last_slot || pad_otpt_lst_i);
`else
        cmp       = beat_ok && last_slot;
`endif
        rel       = (bank_st[rd_ptr_q] == BANK_FULL) && blk_rdy_i;
        wr_ptr_d  = wr_ptr_q ^ cmp;
        rd_ptr_d  = rd_ptr_q ^ rel;
        // A one-beat message both consumes and re-arms fst_pend; re-arm wins.
        fst_pend_d = fst_pend_q;
        if (beat_ok && wr_empty) begin
            fst_pend_d = 1'b0;
        end
        if (pad_otpt_vld_i && pad_otpt_lst_i) begin
            fst_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fst_pend_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fst_pend_q <= fst_pend_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign bank_beat[gi] = beat_ok && (wr_ptr_q == 1'(gi));
        assign bank_rel[gi]  = rel && (rd_ptr_q == 1'(gi));

        sm3_blk_bank #(
            .INPT_DW (INPT_DW)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .beat_i   (bank_beat[gi]),
            .beat_d_i (pad_otpt_d_i),
            .fst_i    (fst_pend_q),
            .cmp_i    (cmp),
            .lst_i    (pad_otpt_lst_i),
            .rel_i    (bank_rel[gi]),
            .state_o  (bank_st[gi]),
            .cnt_o    (bank_cnt[gi]),
            .data_o   (bank_dat[gi]),
            .fst_o    (bank_fst[gi]),
            .lst_o    (bank_lst[gi])
        );
    end

    assign blk_o          = bank_dat[rd_ptr_q];
    assign blk_fst_o      = bank_fst[rd_ptr_q];
    assign blk_lst_o      = bank_lst[rd_ptr_q];
    assign blk_vld_o      = (bank_st[rd_ptr_q] == BANK_FULL);
    assign pad_otpt_ena_o = !((bank_st[0] == BANK_FULL) || (bank_st[1] == BANK_FULL));

`ifdef SM3_PACK_ERR_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (pad_otpt_vld_i && wr_full)
              | (beat_ok && pad_otpt_lst_i && !last_slot);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_sm3_blk_pack.sv
// Self-checking bench for sm3_blk_pack: 32-bit instance against a block-queue model, plus a 64-bit instance.
module tb_sm3_blk_pack;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [31:0]  d32 = '0;
    logic         vld32 = 1'b0, lst32 = 1'b0, rdy32 = 1'b0;
    logic         ena32, bvld32, bfst32, blst32;
    logic [511:0] blk32;

    logic [63:0]  d64 = '0;
    logic         vld64 = 1'b0, lst64 = 1'b0, rdy64 = 1'b0;
    logic         ena64, bvld64, bfst64, blst64;
    logic [511:0] blk64;

`ifdef SM3_PACK_ERR_CHK_EN
    logic err32, err64;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sm3_blk_pack #(.INPT_DW(32)) dut32 (
        .clk(clk), .rst(rst),
        .pad_otpt_d_i(d32), .pad_otpt_vld_i(vld32), .pad_otpt_lst_i(lst32),
        .pad_otpt_ena_o(ena32),
        .blk_o(blk32), .blk_vld_o(bvld32), .blk_fst_o(bfst32), .blk_lst_o(blst32),
        .blk_rdy_i(rdy32)
`ifdef SM3_PACK_ERR_CHK_EN
        ,.err_o(err32)
`endif
    );

    sm3_blk_pack #(.INPT_DW(64)) dut64 (
        .clk(clk), .rst(rst),
        .pad_otpt_d_i(d64), .pad_otpt_vld_i(vld64), .pad_otpt_lst_i(lst64),
        .pad_otpt_ena_o(ena64),
        .blk_o(blk64), .blk_vld_o(bvld64), .blk_fst_o(bfst64), .blk_lst_o(blst64),
        .blk_rdy_i(rdy64)
`ifdef SM3_PACK_ERR_CHK_EN
        ,.err_o(err64)
`endif
    );

    // Reference model: finished blocks wait in a queue (at most two), the
    // block being assembled accumulates in m_acc.
    typedef struct {
        logic [511:0] data;
        bit           fst;
        bit           lst;
    } blk_t;

    blk_t         mq[$];
    logic [511:0] m_acc;
    int           m_n;
    bit           m_fst;
    bit           m_pend;
    bit           m_err;

    task automatic model_reset();
        mq.delete();
        m_acc  = '0;
        m_n    = 0;
        m_fst  = 0;
        m_pend = 1;
        m_err  = 0;
    endtask

    task automatic model_clock(input bit v, input logic [31:0] d, input bit l, input bit r);
        int   pre;
        bit   close;
        blk_t b;
        pre = mq.size();
        if (v) begin
            if (pre == 2) begin
                m_err = 1;
            end else begin
                if (m_n == 0) begin
                    m_fst  = m_pend;
                    m_pend = 0;
                end
                m_acc = m_acc | ({480'd0, d} << (512 - 32 * (m_n + 1)));
                m_n++;
                close = (m_n == 16);
`ifdef SM3_PACK_ERR_CHK_EN
                if (l && m_n < 16) begin
                    m_err = 1;
                    close = 1;
                end
`endif
                if (close) begin
                    b.data = m_acc;
                    b.fst  = m_fst;
                    b.lst  = l;
                    mq.push_back(b);
                    m_acc = '0;
                    m_n   = 0;
                end
            end
            if (l) m_pend = 1;
        end
        if (pre > 0 && r) begin
            $display("blk released: fst=%0b lst=%0b w0=%08h", mq[0].fst, mq[0].lst, mq[0].data[511:480]);
            void'(mq.pop_front());
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit r);
        @(negedge clk);
        rst = 1'b0; vld32 = v; d32 = d; lst32 = l; rdy32 = r;
        @(posedge clk);
        model_clock(v, d, l, r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld32 = 0; lst32 = 0; rdy32 = 0; d32 = '0;
        vld64 = 0; lst64 = 0; rdy64 = 0; d64 = '0;
        @(posedge clk);
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bvld32 !== 1'b0 || ena32 !== 1'b1 || bfst32 !== 1'b0 || blst32 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: vld=%b ena=%b fst=%b lst=%b, required 0 1 0 0", bvld32, ena32, bfst32, blst32);
        end
        vectors++;
        if (blk32 !== 512'd0 || blk64 !== 512'd0 || bvld64 !== 1'b0 || ena64 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_data: blk32=%h blk64=%h vld64=%b ena64=%b", blk32, blk64, bvld64, ena64);
        end
`ifdef SM3_PACK_ERR_CHK_EN
        vectors++;
        if (err32 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: err=%b required 0", err32);
        end
`endif
    endtask

    task automatic test_abc();
        logic [511:0] exp;
        exp = '0;
        exp[511:480] = 32'h61626380;
        exp[31:0]    = 32'h00000018;
        for (int i = 0; i < 16; i++)
            step(1, (i == 0) ? 32'h61626380 : (i == 15) ? 32'h18 : 32'h0, i == 15, 0);
        vectors++;
        if (bvld32 !== 1'b1 || bfst32 !== 1'b1 || blst32 !== 1'b1 || ena32 !== 1'b0) begin
            miscompares++;
            $display("FAIL abc_ctl: vld=%b fst=%b lst=%b ena=%b, required 1 1 1 0", bvld32, bfst32, blst32, ena32);
        end
        vectors++;
        if (blk32 !== exp) begin
            miscompares++;
            $display("FAIL abc_data: got %h required %h", blk32, exp);
        end
        step(0, 0, 0, 1);
        vectors++;
        if (ena32 !== 1'b1 || bvld32 !== 1'b0) begin
            miscompares++;
            $display("FAIL abc_release: ena=%b vld=%b, required 1 0", ena32, bvld32);
        end
    endtask

    task automatic test_two_block();
        logic [511:0] b0;
        for (int i = 0; i < 16; i++) step(1, $urandom, 0, 0);
        b0 = mq[0].data;
        vectors++;
        if (bvld32 !== 1'b1 || bfst32 !== 1'b1 || blst32 !== 1'b0 || ena32 !== 1'b0 || blk32 !== b0) begin
            miscompares++;
            $display("FAIL two_blk0: vld=%b fst=%b lst=%b ena=%b data_ok=%b, required 1 1 0 0 1",
                     bvld32, bfst32, blst32, ena32, blk32 === b0);
        end
        for (int i = 0; i < 16; i++) step(1, $urandom, i == 15, 0);
        vectors++;
        if (bvld32 !== 1'b1 || blk32 !== b0 || bfst32 !== 1'b1 || mq.size() != 2) begin
            miscompares++;
            $display("FAIL two_hold: vld=%b fst=%b data_ok=%b queued=%0d, required 1 1 1 2",
                     bvld32, bfst32, blk32 === b0, mq.size());
        end
        step(0, 0, 0, 1);
        vectors++;
        if (bvld32 !== 1'b1 || bfst32 !== 1'b0 || blst32 !== 1'b1 || blk32 !== mq[0].data || ena32 !== 1'b0) begin
            miscompares++;
            $display("FAIL two_blk1: vld=%b fst=%b lst=%b ena=%b data_ok=%b, required 1 0 1 0 1",
                     bvld32, bfst32, blst32, ena32, blk32 === mq[0].data);
        end
        step(0, 0, 0, 1);
        vectors++;
        if (bvld32 !== 1'b0 || ena32 !== 1'b1) begin
            miscompares++;
            $display("FAIL two_drain: vld=%b ena=%b, required 0 1", bvld32, ena32);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) step(1, $urandom, 0, 0);
        for (int i = 0; i < 15; i++) step(1, $urandom, 0, 0);
        step(1, $urandom, 1, 1);
        vectors++;
        if (bvld32 !== 1'b1 || bfst32 !== 1'b0 || blst32 !== 1'b1 || blk32 !== mq[0].data || mq.size() != 1) begin
            miscompares++;
            $display("FAIL simul: vld=%b fst=%b lst=%b data_ok=%b queued=%0d, required 1 0 1 1 1",
                     bvld32, bfst32, blst32, blk32 === mq[0].data, mq.size());
        end
        step(0, 0, 0, 1);
        vectors++;
        if (bvld32 !== 1'b0 || ena32 !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_drain: vld=%b ena=%b, required 0 1", bvld32, ena32);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] w0;
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
        do_reset();
        step(0, 0, 0, 0);
        vectors++;
        if (bvld32 !== 1'b0 || ena32 !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst: vld=%b ena=%b, required 0 1", bvld32, ena32);
        end
        w0 = 32'hA5C3_0F1E;
        step(1, w0, 0, 0);
        for (int i = 1; i < 16; i++) step(1, $urandom, i == 15, 0);
        vectors++;
        if (bvld32 !== 1'b1 || bfst32 !== 1'b1 || blk32[511:480] !== w0 || blk32 !== mq[0].data) begin
            miscompares++;
            $display("FAIL midrst_msg: vld=%b fst=%b w0=%h required w0 %h data_ok=%b",
                     bvld32, bfst32, blk32[511:480], w0, blk32 === mq[0].data);
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_random();
        bit v, l, r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 2) == 0);
            step(v, $urandom, l, r);
            vectors++;
            if (bvld32 !== (mq.size() > 0) || ena32 !== (mq.size() == 0)) begin
                miscompares++;
                $display("FAIL rnd_ctl cyc %0d: vld=%b ena=%b, required %b %b",
                         c, bvld32, ena32, mq.size() > 0, mq.size() == 0);
            end
            if (mq.size() > 0) begin
                vectors++;
                if (blk32 !== mq[0].data || bfst32 !== mq[0].fst || blst32 !== mq[0].lst) begin
                    miscompares++;
                    $display("FAIL rnd_blk cyc %0d: fst=%b lst=%b required %b %b data_ok=%b",
                             c, bfst32, blst32, mq[0].fst, mq[0].lst, blk32 === mq[0].data);
                end
            end
`ifdef SM3_PACK_ERR_CHK_EN
            vectors++;
            if (err32 !== m_err) begin
                miscompares++;
                $display("FAIL rnd_err cyc %0d: err=%b required %b", c, err32, m_err);
            end
`endif
        end
        for (int c = 0; c < 3; c++) step(0, 0, 0, 1);
    endtask

    task automatic test_w64();
        logic [63:0]  b [8];
        logic [511:0] exp;
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            b[i] = (i == 0) ? 64'h0123456789ABCDEF : {$urandom, $urandom};
            exp  = exp | ({448'd0, b[i]} << (512 - 64 * (i + 1)));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = 0; vld64 = 1; d64 = b[i]; lst64 = (i == 7); rdy64 = 0;
            @(posedge clk); #1;
            if (i == 6) begin
                vectors++;
                if (bvld64 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL w64_early: vld=%b after 7 beats, required 0", bvld64);
                end
            end
        end
        @(negedge clk); vld64 = 0; lst64 = 0;
        vectors++;
        if (bvld64 !== 1'b1 || blk64[511:448] !== 64'h0123456789ABCDEF || blk64 !== exp ||
            bfst64 !== 1'b1 || blst64 !== 1'b1 || ena64 !== 1'b0) begin
            miscompares++;
            $display("FAIL w64: vld=%b fst=%b lst=%b ena=%b beat0=%h data_ok=%b", bvld64, bfst64, blst64,
                     ena64, blk64[511:448], blk64 === exp);
        end
        rdy64 = 1;
        @(posedge clk); #1;
        @(negedge clk); rdy64 = 0;
        vectors++;
        if (bvld64 !== 1'b0 || ena64 !== 1'b1) begin
            miscompares++;
            $display("FAIL w64_release: vld=%b ena=%b, required 0 1", bvld64, ena64);
        end
    endtask

`ifdef SM3_PACK_ERR_CHK_EN
    task automatic test_err_early_lst();
        logic [511:0] exp;
        logic [31:0]  w;
        do_reset();
        exp = '0;
        for (int i = 0; i < 7; i++) begin
            w = $urandom;
            exp[511 - 32 * i -: 32] = w;
            step(1, w, i == 6, 0);
        end
        vectors++;
        if (err32 !== 1'b1 || bvld32 !== 1'b1 || blst32 !== 1'b1 || bfst32 !== 1'b1 || blk32 !== exp) begin
            miscompares++;
            $display("FAIL err_lst: err=%b vld=%b fst=%b lst=%b data_ok=%b, required 1 1 1 1 1",
                     err32, bvld32, bfst32, blst32, blk32 === exp);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        vectors++;
        if (err32 !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b required 1", err32);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_abc();
        test_two_block();
        test_simultaneous();
        test_mid_reset();
        test_w64();
`ifdef SM3_PACK_ERR_CHK_EN
        test_err_early_lst();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
